// File: rtl/pc_next_unit.sv
// pc_next_unit: PC register, next-PC select and fetch request.
// Optional counters enabled by defining BRANCH_STATS_EN.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    input  logic [2:0]       br_funct3,
    input  logic             breq,
    input  logic             brlt,
    input  logic [31:0]      br_target,
    input  logic             jmp_valid,
    input  logic [31:0]      jmp_target,
    input  logic             stall,
    input  logic             if_gnt,
    output logic             brun,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic             if_req,
    output logic             taken,
    output logic             flush,
`ifdef BRANCH_STATS_EN
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] br_taken_cnt,
    output logic [CNT_W-1:0] jmp_cnt,
`endif
    output logic             misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HOLD  = 2'd2,
        REDIR = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        flush_q, flush_d;
    logic        misalign_q, misalign_d;
    logic        cond;
    logic        active;
    logic        redirect;
    logic [31:0] target;

    assign brun     = br_funct3[1];
    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign flush    = flush_q;
    assign misalign = misalign_q;
    assign taken    = jmp_valid | (br_valid & cond);
    // Nothing sits in execute while booting or flushing.
    assign active   = (state_q == RUN) || (state_q == HOLD);
    assign redirect = active & taken;
    assign target   = jmp_valid ? jmp_target : br_target;

    // Branch condition from comparator flags
    always_comb begin
        cond = 1'b0;
        case (br_funct3)
            3'b000:          cond = breq;
            3'b001:          cond = ~breq;
            3'b100, 3'b110:  cond = brlt;
            3'b101, 3'b111:  cond = ~brlt;
            default:         cond = 1'b0;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:  state_d = RUN;
            RUN:   state_d = redirect ? REDIR : (stall ? HOLD : RUN);
            HOLD:  state_d = redirect ? REDIR : (stall ? HOLD : RUN);
            REDIR: state_d = RUN;
        endcase
    end

    // Next PC, sticky misalign and flush pulse
    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (redirect) begin
            pc_d       = target;
            misalign_d = misalign_q | (|target[1:0]);
        end else if (state_q == RUN && !stall && if_gnt) begin
            pc_d = pc_plus4;
        end
        flush_d = (state_d == REDIR);
    end

    // Fetch request only while running
    always_comb begin
        if_req = (state_q == RUN);
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] bt_cnt_q, bt_cnt_d;
    logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;

    assign br_cnt       = br_cnt_q;
    assign br_taken_cnt = bt_cnt_q;
    assign jmp_cnt      = jmp_cnt_q;

    // Saturating event counters
    always_comb begin
        br_cnt_d  = br_cnt_q;
        bt_cnt_d  = bt_cnt_q;
        jmp_cnt_d = jmp_cnt_q;
        if (active && br_valid && !(&br_cnt_q))
            br_cnt_d = br_cnt_q + 1'b1;
        if (active && br_valid && cond && !(&bt_cnt_q))
            bt_cnt_d = bt_cnt_q + 1'b1;
        if (active && jmp_valid && !(&jmp_cnt_q))
            jmp_cnt_d = jmp_cnt_q + 1'b1;
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q  <= '0;
            bt_cnt_q  <= '0;
            jmp_cnt_q <= '0;
        end else begin
            br_cnt_q  <= br_cnt_d;
            bt_cnt_q  <= bt_cnt_d;
            jmp_cnt_q <= jmp_cnt_d;
        end
    end
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: scoreboard bench for pc_next_unit.
// Define BRANCH_STATS_EN to also check the counters.
module tb_pc_next_unit;

    localparam int S_BOOT  = 0;
    localparam int S_RUN   = 1;
    localparam int S_HOLD  = 2;
    localparam int S_REDIR = 3;

    typedef struct {
        logic [31:0] pc;
        logic        if_req;
        logic        flush;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_funct3 = 3'b0;
    logic        breq = 1'b0;
    logic        brlt = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic        jmp_valid = 1'b0;
    logic [31:0] jmp_target = 32'h0;
    logic        stall = 1'b0;
    logic        if_gnt = 1'b0;
    logic        brun;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        if_req;
    logic        taken;
    logic        flush;
    logic        misalign;
`ifdef BRANCH_STATS_EN
    logic [15:0] br_cnt, br_taken_cnt, jmp_cnt;
    int          m_br, m_bt, m_jc;
`endif

    pc_next_unit #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .br_valid(br_valid),
        .br_funct3(br_funct3),
        .breq(breq),
        .brlt(brlt),
        .br_target(br_target),
        .jmp_valid(jmp_valid),
        .jmp_target(jmp_target),
        .stall(stall),
        .if_gnt(if_gnt),
        .brun(brun),
        .pc(pc),
        .pc_plus4(pc_plus4),
        .if_req(if_req),
        .taken(taken),
        .flush(flush),
`ifdef BRANCH_STATS_EN
        .br_cnt(br_cnt),
        .br_taken_cnt(br_taken_cnt),
        .jmp_cnt(jmp_cnt),
`endif
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    exp_t        sb[$];
    logic [31:0] m_pc = 32'h0;
    int          m_st = S_BOOT;
    logic        m_mis = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc  = 32'h0;
        m_st  = S_BOOT;
        m_mis = 1'b0;
`ifdef BRANCH_STATS_EN
        m_br = 0; m_bt = 0; m_jc = 0;
`endif
    endtask

    // One clock: drive, check comb outputs, predict, then compare.
    task automatic step(input logic bv, input logic [2:0] f3,
                        input logic eq, input logic lt,
                        input logic [31:0] bt, input logic jv,
                        input logic [31:0] jt, input logic st,
                        input logic g);
        logic c, tk, act;
        exp_t e;
        @(negedge clk);
        br_valid = bv; br_funct3 = f3; breq = eq; brlt = lt;
        br_target = bt; jmp_valid = jv; jmp_target = jt;
        stall = st; if_gnt = g;
        #1;
        case (f3)
            3'b000: c = eq;
            3'b001: c = !eq;
            3'b100, 3'b110: c = lt;
            3'b101, 3'b111: c = !lt;
            default: c = 1'b0;
        endcase
        tk  = jv | (bv & c);
        act = (m_st == S_RUN) || (m_st == S_HOLD);
        check("brun", {31'b0, brun}, {31'b0, f3[1]});
        check("taken", {31'b0, taken}, {31'b0, tk});
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
`ifdef BRANCH_STATS_EN
        if (act && bv) m_br++;
        if (act && bv && c) m_bt++;
        if (act && jv) m_jc++;
`endif
        if (act && jv) begin
            m_pc = jt; m_st = S_REDIR;
            if (jt[1:0] != 2'b00) m_mis = 1'b1;
        end else if (act && bv && c) begin
            m_pc = bt; m_st = S_REDIR;
            if (bt[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            case (m_st)
                S_BOOT:  m_st = S_RUN;
                S_RUN: begin
                    if (st) m_st = S_HOLD;
                    else if (g) m_pc = m_pc + 32'd4;
                end
                S_HOLD:  if (!st) m_st = S_RUN;
                default: m_st = S_RUN;
            endcase
        end
        e.pc = m_pc;
        e.if_req = (m_st == S_RUN);
        e.flush = (m_st == S_REDIR);
        e.mis = m_mis;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("pc", pc, e.pc);
            check("if_req", {31'b0, if_req}, {31'b0, e.if_req});
            check("flush", {31'b0, flush}, {31'b0, e.flush});
            check("misalign", {31'b0, misalign}, {31'b0, e.mis});
        end
    endtask

    task automatic seq(input logic g);
        step(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 0, g);
    endtask

    task automatic br(input logic [2:0] f3, input logic eq,
                      input logic lt, input logic [31:0] bt);
        step(1, f3, eq, lt, bt, 0, 32'h0, 0, 1);
    endtask

    task automatic jmp(input logic [31:0] jt);
        step(0, 3'b000, 0, 0, 32'h0, 1, jt, 0, 1);
    endtask

    task automatic stl();
        step(0, 3'b000, 0, 0, 32'h0, 0, 32'h0, 1, 1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2;
        br_valid = 0; jmp_valid = 0; stall = 0; if_gnt = 1;
        rst_n = 1'b1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_pc"}, pc, 32'h0);
        check({tag, "_if_req"}, {31'b0, if_req}, 32'd0);
        check({tag, "_flush"}, {31'b0, flush}, 32'd0);
        check({tag, "_mis"}, {31'b0, misalign}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #2;
        check_reset("rst");
        release_reset();
        #1;
        check("boot_if_req", {31'b0, if_req}, 32'd0);
        // sequential fetch 0x0, 0x4, 0x8 ...
        for (int i = 0; i < 5; i++) seq(1);
        // BEQ taken with coincident grant
        br(3'b000, 1, 0, 32'h40);
        seq(1);
        seq(1);
        // BLTU taken, BGE not taken
        br(3'b110, 0, 1, 32'h80);
        seq(1);
        br(3'b101, 0, 1, 32'h300);
        // jump beats taken branch
        step(1, 3'b000, 1, 0, 32'h200, 1, 32'h100, 0, 1);
        seq(1);
        // stall three cycles at 0x20
        jmp(32'h20);
        seq(0);
        stl(); stl(); stl();
        seq(1);
        seq(1);
        // redirect while held
        stl();
        step(1, 3'b001, 0, 0, 32'h60, 0, 32'h0, 1, 1);
        seq(1);
        // jump in REDIR ignored
        jmp(32'h500);
        jmp(32'h600);
        seq(1);
        // reserved funct3, no grant, other conditions
        br(3'b010, 1, 1, 32'h700);
        br(3'b011, 1, 1, 32'h700);
        seq(0);
        seq(0);
        br(3'b000, 0, 0, 32'h900);
        br(3'b100, 0, 1, 32'hA00);
        seq(1);
        br(3'b111, 0, 0, 32'hB00);
        seq(1);
        br(3'b100, 0, 0, 32'hC00);
        // misalign is sticky, wrap of pc+4
        jmp(32'h102);
        seq(1);
        seq(1);
        jmp(32'hFFFF_FFF8);
        seq(1);
        seq(1);
        seq(1);
        seq(1);
`ifdef BRANCH_STATS_EN
        check("br_cnt", {16'b0, br_cnt}, m_br);
        check("br_taken_cnt", {16'b0, br_taken_cnt}, m_bt);
        check("jmp_cnt", {16'b0, jmp_cnt}, m_jc);
`endif
        // reset while in REDIR
        jmp(32'h44);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset("rst_redir");
        release_reset();
        seq(1);
        seq(1);
        seq(1);
        // reset while in HOLD
        stl();
        stl();
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check_reset("rst_hold");
        release_reset();
        seq(1);
        seq(1);
`ifdef BRANCH_STATS_EN
        check("br_cnt_end", {16'b0, br_cnt}, m_br);
        check("jmp_cnt_end", {16'b0, jmp_cnt}, m_jc);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
